// File: rtl/detector_pisca.sv
// Blink-line monitor: synchronizes led_in, measures period and high time in
// clock cycles, and flags a line that has stopped toggling.
module detector_pisca #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             led_in,
    output logic [WIDTH-1:0] periodo,
    output logic [WIDTH-1:0] alto,
    output logic             valido,
    output logic             parado,
    output logic             nivel
);

    // state  | meaning
    // ESPERA | idle, waiting for the first rise to arm a measurement
    // MEDE   | measuring, every rise reports one full period
    // PARADO | no edge for TIMEOUT cycles, last results held
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        MEDE   = 2'd1,
        PARADO = 2'd2
    } estado_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_CNT = '1;
    localparam logic [WIDTH-1:0] TO_LIM  = WIDTH'(TIMEOUT - 1);

    estado_t          state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             prev_q, prev_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cnt_alto_q, cnt_alto_d;
    logic             fall_seen_q, fall_seen_d;
    logic [WIDTH-1:0] ocioso_q, ocioso_d;
    logic [WIDTH-1:0] periodo_q, periodo_d;
    logic [WIDTH-1:0] alto_q, alto_d;
    logic             valido_q, valido_d;
    logic             parado_q, parado_d;

    logic rise, fall, any_edge;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == MAX_CNT) ? v : v + ONE;
    endfunction

    always_comb begin
        rise     = s2_q & ~prev_q;
        fall     = ~s2_q & prev_q;
        any_edge = rise | fall;

        s1_d        = led_in;
        s2_d        = s1_q;
        prev_d      = s2_q;
        state_d     = state_q;
        cnt_d       = rise ? ONE : sat_inc(cnt_q);
        cnt_alto_d  = cnt_alto_q;
        fall_seen_d = fall_seen_q;
        ocioso_d    = any_edge ? '0 : sat_inc(ocioso_q);
        periodo_d   = periodo_q;
        alto_d      = alto_q;
        valido_d    = 1'b0;
        parado_d    = parado_q;

        case (state_q)
            ESPERA: begin
                if (rise) begin
                    state_d     = MEDE;
                    fall_seen_d = 1'b0;
                end
            end
            MEDE: begin
                if (fall) begin
                    cnt_alto_d  = cnt_q;
                    fall_seen_d = 1'b1;
                end
                if (rise) begin
                    periodo_d   = cnt_q;
                    // No fall inside this period: the line stayed high throughout
                    alto_d      = fall_seen_q ? cnt_alto_q : cnt_q;
                    valido_d    = 1'b1;
                    fall_seen_d = 1'b0;
                end
            end
            PARADO: begin
                if (rise) begin
                    state_d     = MEDE;
                    parado_d    = 1'b0;
                    fall_seen_d = 1'b0;
                end else if (fall) begin
                    state_d  = ESPERA;
                    parado_d = 1'b0;
                end
            end
            default: state_d = ESPERA;
        endcase

        if (!any_edge && (ocioso_q == TO_LIM)) begin
            state_d  = PARADO;
            parado_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ESPERA;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            cnt_alto_q  <= '0;
            fall_seen_q <= 1'b0;
            ocioso_q    <= '0;
            periodo_q   <= '0;
            alto_q      <= '0;
            valido_q    <= 1'b0;
            parado_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            cnt_alto_q  <= cnt_alto_d;
            fall_seen_q <= fall_seen_d;
            ocioso_q    <= ocioso_d;
            periodo_q   <= periodo_d;
            alto_q      <= alto_d;
            valido_q    <= valido_d;
            parado_q    <= parado_d;
        end
    end

    assign periodo = periodo_q;
    assign alto    = alto_q;
    assign valido  = valido_q;
    assign parado  = parado_q;
    assign nivel   = s2_q;

endmodule

// File: tb/tb_detector_pisca.sv
// Bench for detector_pisca: scenario tasks driving led_in synchronously, checked
// against a timestamp-based model of edges, periods and the idle timeout.
module tb_detector_pisca;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;

    logic             clock;
    logic             reset_n;
    logic             led_in;
    logic [WIDTH-1:0] periodo;
    logic [WIDTH-1:0] alto;
    logic             valido;
    logic             parado;
    logic             nivel;

    int errors = 0;
    int checks = 0;

    detector_pisca #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .led_in  (led_in),
        .periodo (periodo),
        .alto    (alto),
        .valido  (valido),
        .parado  (parado),
        .nivel   (nivel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: the synchronizer is a pure two-sample delay; edges are stamped with
    // the clock edge at which they are reported, and results are time differences.
    int         ts;
    int         last_rise, last_fall, last_edge;
    bit         armed, stalled, fall_seen;
    logic       h1, h2, h3;
    logic [15:0] m_periodo, m_alto;
    logic       m_valido;

    logic [2*WIDTH+2:0] dut_vec, exp_vec;
    assign dut_vec = {periodo, alto, valido, parado, nivel};
    assign exp_vec = {m_periodo, m_alto, m_valido, stalled, h2};

    task automatic model_edge(input logic rst_n, input logic lvl);
        ts++;
        m_valido = 1'b0;
        if (!rst_n) begin
            last_rise = ts; last_fall = ts; last_edge = ts;
            armed = 0; stalled = 0; fall_seen = 0;
            h1 = 0; h2 = 0; h3 = 0;
            m_periodo = '0; m_alto = '0;
            return;
        end
        if (h2 && !h3) begin
            if (armed) begin
                m_periodo = 16'(ts - last_rise);
                m_alto    = fall_seen ? 16'(last_fall - last_rise) : 16'(ts - last_rise);
                m_valido  = 1'b1;
            end
            armed = 1; stalled = 0; fall_seen = 0;
            last_rise = ts; last_edge = ts;
        end else if (!h2 && h3) begin
            if (armed) begin
                last_fall = ts;
                fall_seen = 1;
            end
            stalled   = 0;
            last_edge = ts;
        end else if (ts - last_edge == TIMEOUT) begin
            stalled = 1;
            armed   = 0;
        end
        h3 = h2; h2 = h1; h1 = lvl;
    endtask

    task automatic step(input logic lvl);
        led_in = lvl;
        @(posedge clock);
        model_edge(reset_n, led_in);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(1'b1);
        step(1'b0);
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dut=%h required=0", dut_vec);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        int first_par = -1;
        int n_val = 0;
        reset_n = 1'b0;
        step(1'b0);
        reset_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step(1'b0);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL idle step %0d: dut=%h model=%h", i, dut_vec, exp_vec);
            end
            if (parado === 1'b1 && first_par < 0) first_par = i;
            if (valido === 1'b1) n_val++;
        end
        checks++;
        if (first_par != TIMEOUT) begin
            errors++;
            $display("FAIL idle_parado_edge: got %0d required %0d", first_par, TIMEOUT);
        end
        checks++;
        if (n_val != 0) begin
            errors++;
            $display("FAIL idle_no_valido: got %0d pulses required 0", n_val);
        end
    endtask

    task automatic test_steady();
        int n_val = 0;
        int last_val = -1;
        int i;
        for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < 8; b++) begin
                step(b < 3);
                i = p * 8 + b;
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL steady step %0d: dut=%h model=%h", i, dut_vec, exp_vec);
                end
                if (valido === 1'b1) begin
                    if (last_val >= 0) begin
                        checks++;
                        if (i - last_val != 8) begin
                            errors++;
                            $display("FAIL steady_spacing: got %0d required 8", i - last_val);
                        end
                    end
                    last_val = i;
                    n_val++;
                end
            end
        end
        checks++;
        if (periodo !== 16'd8 || alto !== 16'd3) begin
            errors++;
            $display("FAIL steady_values: periodo=%0d alto=%0d required 8/3", periodo, alto);
        end
        checks++;
        if (n_val != 5) begin
            errors++;
            $display("FAIL steady_count: got %0d required 5", n_val);
        end
    endtask

    task automatic test_stall();
        int first_par = -1;
        int late_val = 0;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 8; b++) begin
                step(b < 4);
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL stall_blink step %0d: dut=%h model=%h", p * 8 + b, dut_vec, exp_vec);
                end
            end
        end
        for (int j = 0; j < 30; j++) begin
            step(1'b1);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL stall_hold step %0d: dut=%h model=%h", j, dut_vec, exp_vec);
            end
            if (parado === 1'b1 && first_par < 0) first_par = j;
            if (j >= 3 && valido === 1'b1) late_val++;
        end
        checks++;
        if (first_par != 22) begin
            errors++;
            $display("FAIL stall_parado_edge: got %0d required 22", first_par);
        end
        checks++;
        if (late_val != 0 || periodo !== 16'd8) begin
            errors++;
            $display("FAIL stall_hold_values: valido=%0d periodo=%0d required 0/8", late_val, periodo);
        end
    endtask

    task automatic test_recovery();
        int first_val = -1;
        int n_val = 0;
        int j;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 8; b++) begin
                step(b >= 4);
                j = p * 8 + b;
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL recovery step %0d: dut=%h model=%h", j, dut_vec, exp_vec);
                end
                if (j == 1 || j == 2) begin
                    checks++;
                    if (parado !== (j == 1)) begin
                        errors++;
                        $display("FAIL recovery_parado step %0d: got %b required %b", j, parado, j == 1);
                    end
                end
                if (valido === 1'b1) begin
                    n_val++;
                    if (first_val < 0) begin
                        first_val = j;
                        checks++;
                        if (periodo !== 16'd8 || alto !== 16'd4) begin
                            errors++;
                            $display("FAIL recovery_values: periodo=%0d alto=%0d required 8/4", periodo, alto);
                        end
                    end
                end
            end
        end
        checks++;
        if (first_val != 14 || n_val != 3) begin
            errors++;
            $display("FAIL recovery_valido: first=%0d count=%0d required 14/3", first_val, n_val);
        end
    endtask

    task automatic test_clock_rate();
        for (int i = 0; i < 20; i++) begin
            step(i % 2 == 0);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL clock_rate step %0d: dut=%h model=%h", i, dut_vec, exp_vec);
            end
        end
        checks++;
        if (periodo !== 16'd2 || alto !== 16'd1) begin
            errors++;
            $display("FAIL clock_rate_values: periodo=%0d alto=%0d required 2/1", periodo, alto);
        end
    endtask

    task automatic test_reset_mid();
        int first_val = -1;
        int j;
        for (int i = 0; i < 30; i++) begin
            step((i % 10) < 5);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_pre step %0d: dut=%h model=%h", i, dut_vec, exp_vec);
            end
        end
        reset_n = 1'b0;
        step(1'b1);
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: dut=%h required=0", dut_vec);
        end
        reset_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 10; b++) begin
                step(b < 5);
                j = p * 10 + b;
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL reset_mid_post step %0d: dut=%h model=%h", j, dut_vec, exp_vec);
                end
                if (valido === 1'b1 && first_val < 0) begin
                    first_val = j;
                    checks++;
                    if (periodo !== 16'd10 || alto !== 16'd5) begin
                        errors++;
                        $display("FAIL reset_mid_values: periodo=%0d alto=%0d required 10/5", periodo, alto);
                    end
                end
            end
        end
        checks++;
        if (first_val != 12) begin
            errors++;
            $display("FAIL reset_mid_first_valido: got %0d required 12", first_val);
        end
    endtask

    task automatic test_random();
        int hi, lo;
        for (int k = 0; k < 40; k++) begin
            hi = $urandom_range(1, 12);
            lo = ($urandom_range(0, 5) == 0) ? 25 : $urandom_range(1, 12);
            if ($urandom_range(0, 15) == 0) reset_n = 1'b0;
            for (int j = 0; j < hi + lo; j++) begin
                step(j < hi);
                reset_n = 1'b1;
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL random blk %0d step %0d: dut=%h model=%h", k, j, dut_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        led_in    = 1'b0;
        ts        = 0;
        last_rise = 0; last_fall = 0; last_edge = 0;
        armed = 0; stalled = 0; fall_seen = 0;
        h1 = 0; h2 = 0; h3 = 0;
        m_periodo = '0; m_alto = '0; m_valido = 1'b0;
        #2;
        test_reset();
        test_idle();
        test_steady();
        test_stall();
        test_recovery();
        test_clock_rate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/detector_pisca.md
# detector_pisca

Receive-side companion to the blink generator. It samples an LED/blink line (`led_in`) that is asynchronous to `clock` and synchronizes it. It then measures the blink period and high time in `clock` cycles and flags a line that has stopped toggling. It feeds status/debug logic, or a testbench checker, that must confirm the LED output really blinks at the expected rate.

## Interface
- `WIDTH`, default 16: width of the period/high-time measurements and of the internal counters.
- `TIMEOUT`, default 1000: number of consecutive edge-free cycles before the line is declared stopped. Constraints: 2 ≤ `TIMEOUT` < 2^`WIDTH`.

- `clock`, input, 1: sole clock, rising-edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `led_in`, input, 1: blink line being monitored, asynchronous to `clock`.
- `periodo`, output, `WIDTH`: last measured rising-to-rising interval, in cycles.
- `alto`, output, `WIDTH`: last measured rising-to-falling interval (high time), in cycles.
- `valido`, output, 1: one-cycle pulse; `periodo` and `alto` were updated this cycle.
- `parado`, output, 1: level; no edge for `TIMEOUT` cycles.
- `nivel`, output, 1: synchronized level of `led_in`.

## Operation
- **Synchronizer:** two flops, `s1` ← `led_in` and `s2` ← `s1`, plus `prev` ← `s2`.
  - `rise = s2 & ~prev`; `fall = ~s2 & prev`.
  - `nivel = s2`.
- **Counters:**
  - `cnt` counts cycles since the last rise.
  - `cnt_alto` latches the value of `cnt` at the fall.
  - `ocioso` counts cycles since the last edge of either type.
  - All counters saturate at 2^`WIDTH`−1 and never wrap.
- **FSM states:** `ESPERA` (reset state), `MEDE`, `PARADO`.
- **`ESPERA`:**
  - On `rise`: `cnt` ← 1, go to `MEDE`. Nothing is reported, because the first edge only arms the measurement.
  - `fall` is ignored.
- **`MEDE`:**
  - On `fall`: `cnt_alto` ← `cnt`.
  - On `rise`: `periodo` ← `cnt`, `alto` ← `cnt_alto`, `valido` ← 1 for one cycle, `cnt` ← 1.
  - Otherwise: `cnt` ← `cnt`+1.
- **Timeout:**
  - In any state, `ocioso` resets to 0 on `rise` or `fall`; otherwise it increments.
  - When `ocioso` = `TIMEOUT`−1 and there is no edge this cycle, go to `PARADO` and set `parado` ← 1.
- **`PARADO`:**
  - `periodo` and `alto` hold their last values.
  - `fall` clears `parado` and moves to `ESPERA`.
  - `rise` clears `parado`, sets `cnt` ← 1 and moves to `MEDE` with no report. After a stall, a full period must be re-measured before `valido` fires.
- **High time at or above `cnt`:** if no `fall` occurred between two rises (duty ≥ period), `alto` reports the current `cnt` value.

## Timing
- **Reset values:** all outputs 0. `s1`, `s2`, `prev`, `cnt`, `cnt_alto` and `ocioso` are 0. FSM in `ESPERA`.
- **Reset mid-measurement:** everything above is restored on that edge. No `valido` pulse follows from the interrupted measurement.
- **`led_in` high at reset release:** produces a `rise` two cycles later, which only arms the FSM.
- **Latency:** a `led_in` change set up before clock edge k appears on `nivel` after edge k+1. The matching `valido`, `periodo` and `alto` update lands after edge k+2.
- **Measurement accuracy:** for a stable input of period P cycles and high time H cycles, `periodo` = P and `alto` = H exactly, excluding synchronizer jitter of ±1 cycle on asynchronous input.
- **Minimum input:** pulse width 1 cycle when synchronous; 2 cycles guaranteed when asynchronous.
- **`valido`:** high for exactly one cycle per reported period and never in consecutive cycles unless P = 1, which the synchronizer cannot produce.
- **Edge vs timeout in the same cycle:** the edge wins; there is no `PARADO` entry.
- **`parado` from reset:** with `led_in` low from reset, `parado` rises after the `TIMEOUT`-th clock edge following reset release.

## Test plan
- **Steady blink:** `led_in` 3 cycles high / 5 cycles low, synchronous, `WIDTH`=16 → first `valido` on the second rise. Every following `valido`: `periodo`=8, `alto`=3. Spacing between pulses is 8 cycles.
- **Clock-rate blink:** `led_in` toggling every 1 cycle (generator wired straight to `clock`/2) → `periodo`=2, `alto`=1.
- **Stall:** `TIMEOUT`=20. After a stable 8-cycle blink, hold `led_in` high → `parado`=1 exactly 20 cycles after the last edge. `periodo` stays 8 and no `valido` occurs.
- **Recovery:** from the stall, resume the 4/4 blink → `parado` clears at the first edge. `valido` appears only at the second rise, with `periodo`=8 and `alto`=4.
- **Reset mid-operation:** pulse `reset_n`=0 for 1 cycle during a 10-cycle blink → all outputs 0 on the next edge. No `valido` until two rises after release.
- **Idle from reset:** `TIMEOUT`=5, `led_in`=0 → `parado` rises after the 5th edge post-reset. `valido` never asserts.
